// File: rtl/vcbm_cled_gen.sv
// vcbm_cled_gen: modulo-N up/down counter with synchronous load, terminal
// count / cascade enable outputs and a sticky wrap/saturation flag.
// Optional feature macro: VCBM_CLED_SAT_EN adds the 'sat' input, which turns
// the terminal-count wrap into a hold at the terminal value.
module vcbm_cled_gen #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             ce,
    input  logic             up,
    input  logic             L,
    input  logic [WIDTH-1:0] di,
    input  logic             ovf_clr,
`ifdef VCBM_CLED_SAT_EN
    input  logic             sat,
`endif
    output logic [WIDTH-1:0] out,
    output logic             TC,
    output logic             CEO,
    output logic             ovf
);

    // The modulus is held one bit wider than the counter so that
    // MODULUS == 2**WIDTH still compares correctly against load data.
    localparam logic [WIDTH:0]   LP_MOD = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_out;
    logic             r_ovf;
    logic [WIDTH-1:0] w_outNext;
    logic             w_ovfNext;
    logic [WIDTH-1:0] w_loadVal;
    logic             w_tc;
    logic             w_sat;
    logic             w_event;

`ifdef VCBM_CLED_SAT_EN
    assign w_sat = sat;
`else
    assign w_sat = 1'b0;
`endif

    // Terminal count depends on direction only, so a direction flip moves TC
    // in the same cycle; ce only gates the cascade output.
    always_comb begin
        w_tc = 1'b0;
        if (up) begin
            w_tc = (r_out == LP_MAX);
        end else begin
            w_tc = (r_out == '0);
        end
    end

    // Load data beyond the count range is clamped to the top value, so the
    // counter can never hold an out-of-range value.
    always_comb begin
        w_loadVal = LP_MAX;
        if ({1'b0, di} < LP_MOD) begin
            w_loadVal = di;
        end
    end

    // Next-state selection: load beats counting beats hold. Wrap is decided
    // by the terminal compare, so the +1/-1 below never needs a carry.
    always_comb begin
        w_outNext = r_out;
        w_event   = 1'b0;
        if (L) begin
            w_outNext = w_loadVal;
        end else if (ce) begin
            w_event = w_tc;
            if (w_tc && w_sat) begin
                w_outNext = r_out;
            end else if (up) begin
                w_outNext = w_tc ? '0 : r_out + WIDTH'(1);
            end else begin
                w_outNext = w_tc ? LP_MAX : r_out - WIDTH'(1);
            end
        end
    end

    // Sticky flag: a wrap/saturation event on this edge wins over a clear.
    always_comb begin
        w_ovfNext = r_ovf;
        if (w_event) begin
            w_ovfNext = 1'b1;
        end else if (ovf_clr) begin
            w_ovfNext = 1'b0;
        end
    end

    // Count and flag registers; the asynchronous clear discards everything,
    // including a load that was set up for the coming edge.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_out <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_out <= w_outNext;
            r_ovf <= w_ovfNext;
        end
    end

    assign out = r_out;
    assign ovf = r_ovf;
    assign TC  = w_tc;
    assign CEO = ce & w_tc;

endmodule

// File: tb/tb_vcbm_cled_gen.sv
// tb_vcbm_cled_gen: directed and randomized checks of vcbm_cled_gen with
// WIDTH=4, MODULUS=10 against a arithmetic reference model.
// The saturate scenario is exercised only when VCBM_CLED_SAT_EN is defined.
module tb_vcbm_cled_gen;

    localparam int WIDTH   = 4;
    localparam int MODULUS = 10;

    logic             clk;
    logic             clr_n;
    logic             ce;
    logic             up;
    logic             L;
    logic [WIDTH-1:0] di;
    logic             ovf_clr;
    logic             sat;
    logic [WIDTH-1:0] out;
    logic             TC;
    logic             CEO;
    logic             ovf;

    int testCount = 0;
    int failCount = 0;

    // Reference model state: plain integers
    int mOut = 0;
    int mOvf = 0;

    vcbm_cled_gen #(
        .WIDTH  (WIDTH),
        .MODULUS(MODULUS)
    ) dut (
        .clk    (clk),
        .clr_n  (clr_n),
        .ce     (ce),
        .up     (up),
        .L      (L),
        .di     (di),
        .ovf_clr(ovf_clr),
`ifdef VCBM_CLED_SAT_EN
        .sat    (sat),
`endif
        .out    (out),
        .TC     (TC),
        .CEO    (CEO),
        .ovf    (ovf)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it and reports a failure through the assertion
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int modelTc(input int curOut, input logic dirUp);
        if (dirUp) return (curOut == MODULUS - 1) ? 1 : 0;
        return (curOut == 0) ? 1 : 0;
    endfunction

    // Drive one cycle of inputs, check the combinational outputs before the
    // edge, advance the model, then check registered outputs after the edge.
    task automatic applyStimulus(input string tag, input logic iCe, input logic iUp,
                                 input logic iL, input logic [WIDTH-1:0] iDi,
                                 input logic iOvfClr, input logic iSat);
        int tc;
        int satOn;
        ce      = iCe;
        up      = iUp;
        L       = iL;
        di      = iDi;
        ovf_clr = iOvfClr;
        sat     = iSat;
        #1;
        tc = modelTc(mOut, iUp);
        checkOutput({tag, " TC"}, {31'b0, TC}, tc);
        checkOutput({tag, " CEO"}, {31'b0, CEO}, (iCe && tc != 0) ? 1 : 0);
`ifdef VCBM_CLED_SAT_EN
        satOn = iSat ? 1 : 0;
`else
        satOn = 0;
`endif
        if (iL) begin
            mOut = (int'(iDi) < MODULUS) ? int'(iDi) : MODULUS - 1;
            if (iOvfClr) mOvf = 0;
        end else if (iCe) begin
            if (tc != 0) mOvf = 1;
            else if (iOvfClr) mOvf = 0;
            if (!(tc != 0 && satOn != 0)) begin
                if (iUp) mOut = (mOut + 1) % MODULUS;
                else     mOut = (mOut + MODULUS - 1) % MODULUS;
            end
        end else if (iOvfClr) begin
            mOvf = 0;
        end
        @(posedge clk);
        #1;
        checkOutput({tag, " out"}, {28'b0, out}, mOut);
        checkOutput({tag, " ovf"}, {31'b0, ovf}, mOvf);
    endtask

    initial begin
        clr_n   = 1'b0;
        ce      = 1'b0;
        up      = 1'b1;
        L       = 1'b0;
        di      = '0;
        ovf_clr = 1'b0;
        sat     = 1'b0;
        #2;
        // Reset state, checked without any clock edge
        checkOutput("rst out", {28'b0, out}, 0);
        checkOutput("rst ovf", {31'b0, ovf}, 0);
        checkOutput("rst TC up", {31'b0, TC}, 0);
        up = 1'b0;
        ce = 1'b1;
        #1;
        checkOutput("rst TC down", {31'b0, TC}, 1);
        checkOutput("rst CEO down", {31'b0, CEO}, 1);
        @(posedge clk);
        #1;
        checkOutput("rst held out", {28'b0, out}, 0);
        clr_n = 1'b1;
        mOut  = 0;
        mOvf  = 0;

        // Count up through the full range and wrap
        for (int i = 0; i < 10; i++) begin
            applyStimulus($sformatf("up%0d", i), 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        end
        checkOutput("wrap out", {28'b0, out}, 0);
        checkOutput("wrap ovf", {31'b0, ovf}, 1);

        // Clear on a wrap edge loses to the set; clear on a plain edge works
        for (int i = 0; i < 9; i++) begin
            applyStimulus($sformatf("climb%0d", i), 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        end
        applyStimulus("clr on wrap", 1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        checkOutput("clr on wrap kept", {31'b0, ovf}, 1);
        applyStimulus("clr plain", 1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        checkOutput("clr plain cleared", {31'b0, ovf}, 0);

        // Down-count wrap from zero
        applyStimulus("load0", 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        applyStimulus("down wrap", 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("down wrap out", {28'b0, out}, 9);

        // Loads: in range, then clamped; ovf unchanged
        applyStimulus("load7", 1'b0, 1'b1, 1'b1, 4'd7, 1'b0, 1'b0);
        checkOutput("load7 out", {28'b0, out}, 7);
        applyStimulus("load12", 1'b0, 1'b1, 1'b1, 4'd12, 1'b0, 1'b0);
        checkOutput("load12 clamp", {28'b0, out}, 9);
        checkOutput("load12 ovf", {31'b0, ovf}, 1);

        // Asynchronous clear pulsed between edges
        applyStimulus("load5", 1'b0, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0);
        clr_n = 1'b0;
        #2;
        checkOutput("async out", {28'b0, out}, 0);
        checkOutput("async ovf", {31'b0, ovf}, 0);
        clr_n = 1'b1;
        mOut  = 0;
        mOvf  = 0;
        #1;

`ifdef VCBM_CLED_SAT_EN
        // Saturate at the top value
        applyStimulus("sat load9", 1'b0, 1'b1, 1'b1, 4'd9, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus($sformatf("sat%0d", i), 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1);
            checkOutput($sformatf("sat%0d hold", i), {28'b0, out}, 9);
        end
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            applyStimulus($sformatf("rnd%0d", i),
                          ($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 7) == 0),
                          4'($urandom_range(0, 15)),
                          ($urandom_range(0, 5) == 0),
                          1'($urandom_range(0, 1)));
            checkOutput($sformatf("rnd%0d range", i), {31'b0, (int'(out) < MODULUS)}, 1);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
